// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states,
// iteration count and the signed-op decode helper.
package muldiv_pkg;

  localparam int MULDIV_ITER = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } stateT;

  function automatic logic isSignedOp(input logic [2:0] opCode);
    return (opCode == OP_MULT) || (opCode == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring divider on unsigned magnitudes: one shift-subtract step per cycle
// while step is high. Only instantiated when MULDIV_DIV_EN is defined.
module muldiv_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem, quo, dvsr;
  logic [WIDTH-1:0] shiftLow, diff;
  logic             geq;

  // A set MSB in the partial remainder means the shifted value exceeds any
  // WIDTH-bit divisor, so the subtraction always fits back into WIDTH bits.
  assign shiftLow = {rem[WIDTH-2:0], quo[WIDTH-1]};
  assign geq      = rem[WIDTH-1] || (shiftLow >= dvsr);
  assign diff     = shiftLow - dvsr;

  // NOTE: datapath registers carry no reset; they are always loaded on accept
  // before anything reads them, and the owning FSM is what gets reset.
  always_ff @(posedge clk) begin
    if (load) begin
      rem  <= '0;
      quo  <= dividend;
      dvsr <= divisor;
    end else if (step) begin
      rem <= geq ? diff : shiftLow;
      quo <= {quo[WIDTH-2:0], geq};
    end
  end

  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers. Divide support is
// compiled in only when MULDIV_DIV_EN is defined; otherwise DIV/DIVU are NOPs.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = MULDIV_ITER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] RsData,
  input  logic [WIDTH-1:0] RtData,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HiData,
  output logic [WIDTH-1:0] LoData
);

  localparam int CW = $clog2(ITER + 1);

  stateT              state, nextState;
  logic               iterOp, accept, signedIn, negSign, doneReg;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   absA, absB, magA, hiReg, loReg, resHi, resLo;
  logic [WIDTH:0]     addSum;
  logic [2*WIDTH-1:0] acc, product;

`ifdef MULDIV_DIV_EN
  logic             isDiv, divZero, negRem;
  logic [WIDTH-1:0] rsRaw, quotient, remainder;

  assign iterOp = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);

  muldiv_div_core #(.WIDTH(WIDTH)) divCore (
    .clk       (clk),
    .load      (accept),
    .step      (state == RUN),
    .dividend  (absA),
    .divisor   (absB),
    .quotient  (quotient),
    .remainder (remainder)
  );
`else
  assign iterOp = (op == OP_MULT) || (op == OP_MULTU);
`endif

  assign accept   = (state == IDLE) && start && iterOp;
  assign signedIn = isSignedOp(op);
  assign absA     = (signedIn && RsData[WIDTH-1]) ? -RsData : RsData;
  assign absB     = (signedIn && RtData[WIDTH-1]) ? -RtData : RtData;

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // NOTE: defaults first so no path through the case leaves nextState
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = RUN;
      RUN:     if (count == CW'(1)) nextState = FIX;
      FIX:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Shift-add multiply: multiplier sits in the low half and drains out as the
  // partial product shifts in from the top.
  assign addSum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, magA} : '0);

  always_ff @(posedge clk) begin
    if (accept) begin
      count   <= CW'(ITER);
      magA    <= absA;
      acc     <= {{WIDTH{1'b0}}, absB};
      negSign <= signedIn && (RsData[WIDTH-1] ^ RtData[WIDTH-1]);
`ifdef MULDIV_DIV_EN
      isDiv   <= op[1];
      divZero <= (RtData == '0);
      negRem  <= signedIn && RsData[WIDTH-1];
      rsRaw   <= RsData;
`endif
    end else if (state == RUN) begin
      count <= count - 1'b1;
      acc   <= {addSum, acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    product = negSign ? -acc : acc;
    resHi   = product[2*WIDTH-1:WIDTH];
    resLo   = product[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    if (isDiv) begin
      if (divZero) begin
        resHi = rsRaw;
        resLo = '1;
      end else begin
        resHi = negRem  ? -remainder : remainder;
        resLo = negSign ? -quotient  : quotient;
      end
    end
`endif
  end

  // MTHI/MTLO are only honoured in IDLE; a start seen in RUN/FIX is dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hiReg   <= '0;
      loReg   <= '0;
      doneReg <= 1'b0;
    end else begin
      doneReg <= (state == FIX);
      if (state == FIX) begin
        hiReg <= resHi;
        loReg <= resLo;
      end else if (state == IDLE && start && op == OP_MTHI) begin
        hiReg <= RsData;
      end else if (state == IDLE && start && op == OP_MTLO) begin
        loReg <= RsData;
      end
    end
  end

  assign busy   = (state != IDLE);
  assign done   = doneReg;
  assign HiData = hiReg;
  assign LoData = loReg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed scenarios plus random ops
// compared against an arithmetic HI/LO model. Honours MULDIV_DIV_EN.
module tb_muldiv_unit;

  localparam int W = 32;

`ifdef MULDIV_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, start;
  logic [2:0]   op;
  logic [W-1:0] RsData, RtData;
  logic         busy, done;
  logic [W-1:0] HiData, LoData;

  int nChecks = 0;
  int nFails  = 0;
  logic [W-1:0] mHi = '0;
  logic [W-1:0] mLo = '0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W), .ITER(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .RsData (RsData),
    .RtData (RtData),
    .busy   (busy),
    .done   (done),
    .HiData (HiData),
    .LoData (LoData)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit isIterOp(input logic [2:0] o);
    return (o == 3'd0) || (o == 3'd1) || (DivEn && ((o == 3'd2) || (o == 3'd3)));
  endfunction

  // Reference HI/LO semantics from plain 64-bit arithmetic.
  task automatic modelUpdate(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (o)
      3'd0: begin sp = sa * sb; {mHi, mLo} = sp; end
      3'd1: begin up = ua * ub; {mHi, mLo} = up; end
      3'd2, 3'd3: if (DivEn) begin
        if (b == '0) begin
          mHi = a;
          mLo = '1;
        end else if (o == 3'd2) begin
          sp = sa / sb; mLo = sp[W-1:0];
          sp = sa % sb; mHi = sp[W-1:0];
        end else begin
          up = ua / ub; mLo = up[W-1:0];
          up = ua % ub; mHi = up[W-1:0];
        end
      end
      3'd4: mHi = a;
      3'd5: mLo = a;
      default: ;
    endcase
  endtask

  // Issue one op, scramble operands after accept, optionally fire ignored
  // starts while busy, then verify busy length, done pulse and HI/LO.
  task automatic runOp(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input string tag, input bit inject);
    int busyCycles, doneCount, doneAt;
    @(negedge clk);
    start = 1'b1; op = o; RsData = a; RtData = b;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); RsData = $urandom; RtData = $urandom;
    modelUpdate(o, a, b);
    if (isIterOp(o)) begin
      busyCycles = 0; doneCount = 0; doneAt = -1;
      for (int i = 0; i < 40; i++) begin
        if (inject && i == 5)  begin start = 1'b1; op = 3'd5; RsData = 32'h0000_DEAD; end
        if (inject && i == 6)  begin op = 3'd0; RsData = 32'd9; RtData = 32'd9; end
        if (inject && i == 7)  start = 1'b0;
        if (inject && i == 32) begin start = 1'b1; op = 3'd4; RsData = 32'h5555_5555; end
        if (inject && i == 33) start = 1'b0;
        if (busy) busyCycles++;
        if (done) begin
          doneCount++;
          if (doneAt < 0) doneAt = i;
        end
        @(negedge clk);
      end
      check($sformatf("%s busy cycles", tag), 64'(busyCycles), 64'd33);
      check($sformatf("%s done count", tag), 64'(doneCount), 64'd1);
      check($sformatf("%s done position", tag), 64'(doneAt), 64'd33);
    end else begin
      check($sformatf("%s busy", tag), 64'(busy), 64'd0);
      check($sformatf("%s done", tag), 64'(done), 64'd0);
    end
    check($sformatf("%s HI", tag), 64'(HiData), 64'(mHi));
    check($sformatf("%s LO", tag), 64'(LoData), 64'(mLo));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int doneSeen;
    reset = 1'b0; start = 1'b0; op = 3'd7; RsData = '0; RtData = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset HI", 64'(HiData), 64'd0);
    check("reset LO", 64'(LoData), 64'd0);
    reset = 1'b1;

    runOp(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu max", 1'b0);
    check("multu max HI const", 64'(HiData), 64'hFFFF_FFFE);
    check("multu max LO const", 64'(LoData), 64'h0000_0001);
    runOp(3'd0, 32'hFFFF_FFFD, 32'd5, "mult -3x5", 1'b0);
    check("mult -3x5 HI const", 64'(HiData), 64'hFFFF_FFFF);
    check("mult -3x5 LO const", 64'(LoData), 64'hFFFF_FFF1);
    runOp(3'd0, 32'h8000_0000, 32'h8000_0000, "mult minxmin", 1'b0);
    check("mult minxmin HI const", 64'(HiData), 64'h4000_0000);
    check("mult minxmin LO const", 64'(LoData), 64'h0);

    runOp(3'd3, 32'd100, 32'd7, "divu 100/7", 1'b0);
`ifdef MULDIV_DIV_EN
    check("divu 100/7 LO const", 64'(LoData), 64'h0000_000E);
    check("divu 100/7 HI const", 64'(HiData), 64'h0000_0002);
`endif
    runOp(3'd2, 32'hFFFF_FFF9, 32'd2, "div -7/2", 1'b0);
`ifdef MULDIV_DIV_EN
    check("div -7/2 LO const", 64'(LoData), 64'hFFFF_FFFD);
    check("div -7/2 HI const", 64'(HiData), 64'hFFFF_FFFF);
`endif
    runOp(3'd3, 32'h0000_1234, 32'd0, "divu by zero", 1'b0);
`ifdef MULDIV_DIV_EN
    check("divu by zero LO const", 64'(LoData), 64'hFFFF_FFFF);
    check("divu by zero HI const", 64'(HiData), 64'h0000_1234);
`endif
    runOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div overflow", 1'b0);
`ifdef MULDIV_DIV_EN
    check("div overflow LO const", 64'(LoData), 64'h8000_0000);
    check("div overflow HI const", 64'(HiData), 64'h0);
`endif

    runOp(3'd4, 32'h2333_2333, 32'd0, "mthi", 1'b0);
    check("mthi HI const", 64'(HiData), 64'h2333_2333);
    runOp(3'd1, 32'd2, 32'd3, "multu 2x3 with ignored starts", 1'b1);
    check("multu 2x3 HI const", 64'(HiData), 64'h0);
    check("multu 2x3 LO const", 64'(LoData), 64'h6);

    // Reset in the tenth RUN cycle discards the in-flight product.
    @(negedge clk);
    start = 1'b1; op = 3'd1; RsData = 32'd7; RtData = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mHi = '0; mLo = '0;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    check("midreset HI", 64'(HiData), 64'd0);
    check("midreset LO", 64'(LoData), 64'd0);
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) doneSeen++;
      @(negedge clk);
    end
    check("midreset no done", 64'(doneSeen), 64'd0);
    runOp(3'd1, 32'd4, 32'd5, "multu 4x5 after reset", 1'b0);
    check("multu 4x5 LO const", 64'(LoData), 64'd20);

    for (int n = 0; n < 60; n++) begin
      runOp(3'($urandom_range(0, 7)), pick(), pick(), $sformatf("random op %0d", n), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
